// File: rtl/loop_driver_seq.sv
// -----------------------------------------------------------------------------
// loop_driver_seq
//   Switching sequencer for a half-bridge power stage. Alternates top and
//   bottom switch commands with dead time between them. Top on-time is
//   bounded by peak-current detection (after a blanking window) and by a hard
//   on-time limit. The bottom switch ends either on the next period tick
//   (continuous conduction) or on a current zero-crossing (discontinuous
//   conduction). A dead-time state whose switch-off status never arrives goes
//   to a sticky FAULT state, which is left only when run drops.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   enable_driver in   sequencer enable
//   ok_driver     in   driver supply OK
//   pwm_start     in   single-cycle switching-period tick
//   topswipeak    in   top switch peak-current reached
//   botswzcross   in   bottom switch current zero-crossing
//   topswstatus   in   top switch sensed on
//   botswstatus   in   bottom switch sensed on
//   topstate      out  top switch command (registered)
//   botstate      out  bottom switch command (registered)
//   fault         out  status-timeout flag (registered)
//   seq_state     out  current state: IDLE=0 DT_TOP=1 TOP_ON=2 DT_BOT=3
//                      BOT_ON=4 FAULT=5
// -----------------------------------------------------------------------------
module loop_driver_seq #(
    parameter int DEADTIME       = 4,
    parameter int TON_MIN        = 3,
    parameter int TON_MAX        = 20,
    parameter int STATUS_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_driver,
    input  logic       ok_driver,
    input  logic       pwm_start,
    input  logic       topswipeak,
    input  logic       botswzcross,
    input  logic       topswstatus,
    input  logic       botswstatus,
    output logic       topstate,
    output logic       botstate,
    output logic       fault,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DT_TOP = 3'd1,
        S_TOP_ON = 3'd2,
        S_DT_BOT = 3'd3,
        S_BOT_ON = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [7:0] DT_LOAD   = 8'(DEADTIME);
    localparam logic [7:0] TON_MIN_C = 8'(TON_MIN);
    localparam logic [7:0] TON_LAST  = 8'(TON_MAX - 1);
    localparam logic [7:0] TO_LAST   = 8'(STATUS_TIMEOUT - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] sat_dec(input logic [7:0] v);
        return (v == 8'h00) ? v : v - 8'd1;
    endfunction

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_dt;     // dead-time remaining
    logic [7:0] r_to;     // cycles spent waiting in a dead-time state
    logic [7:0] r_ton;    // cycles spent in TOP_ON
    logic [7:0] w_dt;
    logic [7:0] w_to;
    logic [7:0] w_ton;
    logic       w_run;
    logic       w_to_expired;
    logic       w_top_exit;

    always_comb begin
        w_run        = enable_driver & ok_driver;
        w_next       = r_state;
        w_dt         = sat_dec(r_dt);
        w_to         = sat_inc(r_to);
        w_ton        = sat_inc(r_ton);
        w_to_expired = (r_to >= TO_LAST);
        // Peak current only counts once the blanking window has passed.
        w_top_exit   = (topswipeak && (r_ton >= TON_MIN_C)) || (r_ton >= TON_LAST);

        if (!w_run) begin
            w_next = S_IDLE;
            w_dt   = '0;
            w_to   = '0;
            w_ton  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (pwm_start) begin
                        w_next = S_DT_TOP;
                        w_dt   = DT_LOAD;
                        w_to   = '0;
                    end
                end
                S_DT_TOP: begin
                    // The pwm_start cycle itself already has both switches off,
                    // so the top side leaves as the counter decrements to zero.
                    if (!botswstatus && (r_dt <= 8'd1)) begin
                        w_next = S_TOP_ON;
                        w_ton  = '0;
                    end else if (botswstatus && w_to_expired) begin
                        w_next = S_FAULT;
                    end
                end
                S_TOP_ON: begin
                    if (w_top_exit) begin
                        w_next = S_DT_BOT;
                        w_dt   = DT_LOAD;
                        w_to   = '0;
                    end
                end
                S_DT_BOT: begin
                    // Bottom side waits for the counter to read zero, giving
                    // DEADTIME+1 off cycles after the top command falls.
                    if (!topswstatus && (r_dt == 8'd0)) begin
                        w_next = S_BOT_ON;
                    end else if (topswstatus && w_to_expired) begin
                        w_next = S_FAULT;
                    end
                end
                S_BOT_ON: begin
                    // A new period tick takes priority over zero-crossing.
                    if (pwm_start) begin
                        w_next = S_DT_TOP;
                        w_dt   = DT_LOAD;
                        w_to   = '0;
                    end else if (botswzcross) begin
                        w_next = S_IDLE;
                    end
                end
                S_FAULT: begin
                    w_next = S_FAULT;
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_dt      <= '0;
            r_to      <= '0;
            r_ton     <= '0;
            topstate  <= 1'b0;
            botstate  <= 1'b0;
            fault     <= 1'b0;
            seq_state <= 3'd0;
        end else begin
            r_state   <= w_next;
            r_dt      <= w_dt;
            r_to      <= w_to;
            r_ton     <= w_ton;
            // Outputs are decoded from the next state so they line up with
            // the state register without a combinational path to the pins.
            topstate  <= (w_next == S_TOP_ON);
            botstate  <= (w_next == S_BOT_ON);
            fault     <= (w_next == S_FAULT);
            seq_state <= w_next;
        end
    end

endmodule

// File: tb/tb_loop_driver_seq.sv
module tb_loop_driver_seq;

    localparam int DEADTIME       = 4;
    localparam int TON_MIN        = 3;
    localparam int TON_MAX        = 20;
    localparam int STATUS_TIMEOUT = 16;

    logic       clk;
    logic       rst;
    logic       enable_driver;
    logic       ok_driver;
    logic       pwm_start;
    logic       topswipeak;
    logic       botswzcross;
    logic       topswstatus;
    logic       botswstatus;
    logic       topstate;
    logic       botstate;
    logic       fault;
    logic [2:0] seq_state;

    int checks = 0;
    int errors = 0;
    bit started = 0;
    bit done = 0;

    logic [5:0] sb[$];

    // Reference model: current mode and number of cycles already spent in it.
    int m_st = 0;
    int m_el = 0;

    loop_driver_seq #(
        .DEADTIME(DEADTIME),
        .TON_MIN(TON_MIN),
        .TON_MAX(TON_MAX),
        .STATUS_TIMEOUT(STATUS_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable_driver(enable_driver),
        .ok_driver(ok_driver),
        .pwm_start(pwm_start),
        .topswipeak(topswipeak),
        .botswzcross(botswzcross),
        .topswstatus(topswstatus),
        .botswstatus(botswstatus),
        .topstate(topstate),
        .botstate(botstate),
        .fault(fault),
        .seq_state(seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step(input logic r, input logic e, input logic o, input logic p,
                              input logic ip, input logic zc, input logic ts, input logic bs);
        int nst;
        nst = m_st;
        if (r || !(e && o)) begin
            nst = 0;
        end else begin
            case (m_st)
                0: if (p) nst = 1;
                1: begin
                    if (!bs && (m_el + 1 >= DEADTIME)) nst = 2;
                    else if (bs && (m_el + 1 >= STATUS_TIMEOUT)) nst = 5;
                end
                2: if ((ip && m_el >= TON_MIN) || (m_el + 1 >= TON_MAX)) nst = 3;
                3: begin
                    if (!ts && (m_el >= DEADTIME)) nst = 4;
                    else if (ts && (m_el + 1 >= STATUS_TIMEOUT)) nst = 5;
                end
                4: begin
                    if (p) nst = 1;
                    else if (zc) nst = 0;
                end
                default: nst = 5;
            endcase
        end
        if (r || nst != m_st) m_el = 0;
        else m_el = m_el + 1;
        m_st = nst;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drv(input logic r, input logic e, input logic o, input logic p,
                       input logic ip, input logic zc, input logic ts, input logic bs);
        logic [5:0] exp;
        rst           = r;
        enable_driver = e;
        ok_driver     = o;
        pwm_start     = p;
        topswipeak    = ip;
        botswzcross   = zc;
        topswstatus   = ts;
        botswstatus   = bs;
        model_step(r, e, o, p, ip, zc, ts, bs);
        exp = {3'(m_st), (m_st == 2), (m_st == 4), (m_st == 5)};
        sb.push_back(exp);
        started = 1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected output word per clock edge.
    initial begin
        logic [5:0] exp;
        logic [5:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            if (started) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty t=%0t", $time);
                end else begin
                    exp = sb.pop_front();
                    act = {seq_state, topstate, botstate, fault};
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL outputs act seq=%0d t=%b b=%b f=%b exp seq=%0d t=%b b=%b f=%b t=%0t",
                                 act[5:3], act[2], act[1], act[0], exp[5:3], exp[2], exp[1], exp[0], $time);
                    end
                end
                checks++;
                if (topstate && botstate) begin
                    errors++;
                    $display("FAIL overlap act=11 exp=not both t=%0t", $time);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ntop;
        logic rts;
        logic rbs;
        rst = 1'b1; enable_driver = 1'b0; ok_driver = 1'b0; pwm_start = 1'b0;
        topswipeak = 1'b0; botswzcross = 1'b0; topswstatus = 1'b0; botswstatus = 1'b0;

        // Reset
        for (int i = 0; i < 3; i++) begin tick(); drv(1, 1, 1, 1, 1, 1, 0, 0); end
        tick(); chk("reset_seq", seq_state, 0); chk("reset_top", topstate, 0);
        drv(0, 1, 1, 0, 0, 0, 0, 0);

        // Nominal period: pwm at cycle 0, peak at cycle 9
        tick(); drv(0, 1, 1, 1, 0, 0, 0, 0);
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c <= 4) chk("dt_top_seq", seq_state, 1);
            else if (c <= 9) chk("top_on", topstate, 1);
            else if (c <= 14) chk("dt_bot_seq", seq_state, 3);
            else chk("bot_on", botstate, 1);
            drv(0, 1, 1, 0, (c == 9), 0, 0, 0);
        end
        tick(); drv(0, 1, 1, 0, 0, 1, 0, 0);
        tick(); chk("dcm_idle", seq_state, 0); chk("dcm_bot", botstate, 0);
        drv(0, 1, 1, 0, 0, 0, 0, 0);

        // Blanking: peak held from the start
        tick(); drv(0, 1, 1, 1, 0, 0, 0, 0);
        ntop = 0;
        for (int c = 1; c <= 16; c++) begin
            tick(); ntop += int'(topstate);
            drv(0, 1, 1, 0, 1, 0, 0, 0);
        end
        chk("blank_len", ntop, TON_MIN + 1);
        tick(); drv(0, 1, 1, 1, 0, 1, 0, 0);
        // CCM restart, then no peak: limited by TON_MAX
        ntop = 0;
        for (int c = 18; c <= 50; c++) begin
            tick();
            if (c == 18) chk("ccm_seq", seq_state, 1);
            ntop += int'(topstate);
            drv(0, 1, 1, 0, 0, 0, 0, 0);
        end
        chk("tonmax_len", ntop, TON_MAX);
        tick(); drv(0, 1, 1, 0, 0, 1, 0, 0);

        // Fault: top status stuck in DT_BOT
        tick(); drv(0, 1, 1, 1, 0, 0, 0, 0);
        for (int c = 1; c <= 30; c++) begin
            tick(); drv(0, 1, 1, (c == 20 || c == 28), (c == 9), 0, (c >= 9), 0);
        end
        tick();
        chk("fault_flag", fault, 1); chk("fault_seq", seq_state, 5);
        chk("fault_top", topstate, 0); chk("fault_bot", botstate, 0);
        drv(0, 0, 1, 0, 0, 0, 1, 0);
        tick(); chk("fault_clr", fault, 0); chk("fault_idle", seq_state, 0);
        drv(0, 1, 1, 0, 0, 0, 0, 0);

        // ok_driver drop in BOT_ON
        tick(); drv(0, 1, 1, 1, 0, 0, 0, 0);
        for (int c = 1; c <= 15; c++) begin
            tick(); drv(0, 1, 1, 0, (c == 9), 0, 0, 0);
        end
        tick(); chk("okdrop_pre", botstate, 1);
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        tick(); chk("okdrop_bot", botstate, 0); chk("okdrop_seq", seq_state, 0);
        drv(0, 1, 1, 0, 0, 0, 0, 0);

        // Reset during TOP_ON
        tick(); drv(0, 1, 1, 1, 0, 0, 0, 0);
        for (int c = 1; c <= 6; c++) begin
            tick(); drv(0, 1, 1, 0, 0, 0, 0, 0);
        end
        tick(); chk("rst_pre_top", topstate, 1);
        drv(1, 1, 1, 1, 1, 0, 0, 0);
        tick(); chk("rst_top", topstate, 0); chk("rst_seq", seq_state, 0);
        drv(0, 1, 1, 0, 0, 0, 0, 0);

        // Random stimulus with slowly changing status inputs
        rts = 1'b0;
        rbs = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) rts = ~rts;
            if ($urandom_range(0, 24) == 0) rbs = ~rbs;
            tick();
            drv(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) != 0),
                ($urandom_range(0, 59) != 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), rts, rbs);
        end

        @(posedge clk);
        #2;
        done = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
